// File: rtl/dr_pkg.sv
// ============================================================================
// Module   : dr_pkg
// Purpose  : Dual-rail digit encodings and wave phase type shared by the
//            dr_wave_counter block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dr_pkg;

  typedef logic [1:0] dr_digit_t;

  localparam dr_digit_t DR_NULL  = 2'b00;
  localparam dr_digit_t DR_DATA0 = 2'b01;
  localparam dr_digit_t DR_DATA1 = 2'b10;

  typedef enum logic [0:0] {
    PH_DATA = 1'b0,
    PH_NULL = 1'b1
  } phase_t;

  function automatic dr_digit_t dr_encode(input logic b);
    return b ? DR_DATA1 : DR_DATA0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dr_digit_link.sv
// ============================================================================
// Module   : dr_digit_link
// Purpose  : One dual-rail output digit with its four-phase handshake and
//            completeness terms. Optional checks: DR_WAVE_COUNTER_PROTOCOL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dr_digit_link
  import dr_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       data_phase,
  input  logic       val,
  input  logic       comp,
  output logic [1:0] rails,
  output logic       done_data,
  output logic       done_null
`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
  ,
  output logic       viol
`endif
);

  dr_digit_t r_rails;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_rails <= DR_NULL;
    end else if (data_phase && (r_rails == DR_NULL) && !comp) begin
      r_rails <= dr_encode(val);
    end else if (!data_phase && (r_rails != DR_NULL) && comp) begin
      r_rails <= DR_NULL;
    end
  end

  assign rails     = r_rails;
  assign done_data = (r_rails != DR_NULL) && comp;
  assign done_null = (r_rails == DR_NULL) && !comp;

`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
  // Remembers that the previous cycle was already NULL within the DATA phase.
  logic r_null_seen;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_null_seen <= 1'b0;
    end else begin
      r_null_seen <= data_phase && (r_rails == DR_NULL);
    end
  end

  assign viol = (data_phase && (r_rails == DR_NULL) && comp && r_null_seen) ||
                (!data_phase && (r_rails != DR_NULL) && !comp);
`endif

endmodule

`default_nettype wire

// File: rtl/dr_wave_counter.sv
// ============================================================================
// Module   : dr_wave_counter
// Purpose  : Loadable up/down counter emitted as dual-rail NULL/DATA waves,
//            one handshake link per digit plus a carry-out digit.
//            Optional macro: DR_WAVE_COUNTER_PROTOCOL_CHECK_EN (adds proto_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dr_wave_counter
  import dr_pkg::*;
#(
  parameter int                 DIGITS     = 32,
  parameter logic [DIGITS-1:0]  INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DIGITS-1:0]     load_val,
  output logic [2*DIGITS-1:0]   sum,
  input  logic [DIGITS-1:0]     sum_comp,
  output logic [1:0]            carryout,
  input  logic                  carryout_comp
`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
  ,
  output logic                  proto_err
`endif
);

  phase_t            r_phase;
  logic [DIGITS-1:0] r_cnt;
  logic              r_wrap;

  logic [DIGITS:0]   w_val;
  logic [DIGITS:0]   w_comp;
  logic [DIGITS:0]   w_done_data;
  logic [DIGITS:0]   w_done_null;
  logic [1:0]        w_rails [DIGITS+1];
  logic              w_all_data;
  logic              w_all_null;
  logic              w_data_phase;

  // The carry-out link is simply the top lane of the link array.
  assign w_val        = {r_wrap, r_cnt};
  assign w_comp       = {carryout_comp, sum_comp};
  assign w_data_phase = (r_phase == PH_DATA);
  assign w_all_data   = &w_done_data;
  assign w_all_null   = &w_done_null;

`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
  logic [DIGITS:0] w_viol;
`endif

  for (genvar i = 0; i <= DIGITS; i++) begin : g_link
    dr_digit_link u_link (
      .clk        (clk),
      .init_n     (init_n),
      .data_phase (w_data_phase),
      .val        (w_val[i]),
      .comp       (w_comp[i]),
      .rails      (w_rails[i]),
      .done_data  (w_done_data[i]),
      .done_null  (w_done_null[i])
`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
      ,
      .viol       (w_viol[i])
`endif
    );

    if (i < DIGITS) begin : g_sum
      assign sum[2*i+1 -: 2] = w_rails[i];
    end else begin : g_carry
      assign carryout = w_rails[i];
    end
  end

  // Count state changes only on the DATA->NULL wave commit.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_phase <= PH_DATA;
      r_cnt   <= INIT_VALUE;
      r_wrap  <= 1'b0;
    end else begin
      case (r_phase)
        PH_DATA: begin
          if (w_all_data) begin
            r_phase <= PH_NULL;
            if (load) begin
              r_cnt  <= load_val;
              r_wrap <= 1'b0;
            end else if (en && up) begin
              r_cnt  <= r_cnt + 1'b1;
              r_wrap <= &r_cnt;
            end else if (en) begin
              r_cnt  <= r_cnt - 1'b1;
              r_wrap <= ~|r_cnt;
            end else begin
              r_wrap <= 1'b0;
            end
          end
        end
        PH_NULL: begin
          if (w_all_null) begin
            r_phase <= PH_DATA;
          end
        end
        default: r_phase <= PH_DATA;
      endcase
    end
  end

`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
  logic r_proto_err;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_proto_err <= 1'b0;
    end else if (|w_viol) begin
      r_proto_err <= 1'b1;
`ifndef SYNTHESIS
      if (!r_proto_err) begin
        $error("dr_wave_counter: handshake protocol violation, links %b", w_viol);
      end
`endif
    end
  end

  assign proto_err = r_proto_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dr_wave_counter.sv
// ============================================================================
// Module   : tb_dr_wave_counter
// Purpose  : Scoreboard bench for dr_wave_counter (DIGITS=4) with a
//            combinational consumer that can stretch individual completions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dr_wave_counter;

  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              init_n;
  logic              en;
  logic              up;
  logic              load;
  logic [DIGITS-1:0] load_val;
  logic [2*DIGITS-1:0] sum;
  logic [DIGITS-1:0] sum_comp;
  logic [1:0]        carryout;
  logic              carryout_comp;
`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
  logic              proto_err;
`endif

  logic [DIGITS:0]   force_hi;
  logic [DIGITS:0]   force_lo;

  logic [DIGITS:0]   exp_q [$];
  int                n_cmp  = 0;
  int                n_err  = 0;
  int                n_push = 0;
  int                n_pop  = 0;

  dr_wave_counter #(
    .DIGITS     (DIGITS),
    .INIT_VALUE (4'h0)
  ) dut (
    .clk           (clk),
    .init_n        (init_n),
    .en            (en),
    .up            (up),
    .load          (load),
    .load_val      (load_val),
    .sum           (sum),
    .sum_comp      (sum_comp),
    .carryout      (carryout),
    .carryout_comp (carryout_comp)
`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
    ,
    .proto_err     (proto_err)
`endif
  );

  always #5 clk = ~clk;

  // Zero-delay consumer: acknowledges whatever it sees, unless stretched/held.
  always_comb begin
    sum_comp = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sum_comp[i] = ~force_lo[i] & (force_hi[i] | sum[2*i] | sum[2*i+1]);
    end
    carryout_comp = ~force_lo[DIGITS] & (force_hi[DIGITS] | carryout[0] | carryout[1]);
  end

  task automatic push_exp(input logic c, input logic [DIGITS-1:0] v);
    exp_q.push_back({c, v});
    n_push++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic drain();
    wait (n_pop >= n_push);
  endtask

  // Monitor: one comparison per new fully-DATA wave.
  logic prev_all;
  always @(negedge clk) begin
    logic             all_d;
    logic             legal;
    logic [1:0]       d;
    logic [DIGITS-1:0] v;
    logic [DIGITS:0]  got;
    logic [DIGITS:0]  req;
    if (!init_n) begin
      prev_all = 1'b0;
    end else begin
      all_d = 1'b1;
      legal = 1'b1;
      v     = '0;
      for (int i = 0; i < DIGITS; i++) begin
        d = sum[2*i +: 2];
        if (d == 2'b00) all_d = 1'b0;
        if (d == 2'b11) legal = 1'b0;
        v[i] = d[1];
      end
      if (carryout == 2'b00) all_d = 1'b0;
      if (carryout == 2'b11) legal = 1'b0;
      if (all_d && !prev_all) begin
        got = {carryout[1], v};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wave_unexpected: got carry/value %h, required no wave", got);
        end else begin
          req = exp_q.pop_front();
          if (got !== req || !legal) begin
            n_err++;
            $display("FAIL wave: got carry/value %h legal=%0b required %h legal=1", got, legal, req);
          end
        end
        n_pop++;
      end
      prev_all = all_d;
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout, required test completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int pops_before;
    init_n   = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    force_hi = '0;
    force_lo = '0;
    repeat (2) @(negedge clk);
    check("reset_rails", {sum, carryout}, 32'h0);
`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
    check("reset_proto_err", proto_err, 32'h0);
`endif

    // Free-running increment: 0..15 then the wrapped 0 with carry.
    for (int k = 0; k < 16; k++) push_exp(1'b0, 4'(k));
    push_exp(1'b1, 4'h0);
    init_n = 1'b1;
    drain();

    // Load wins over enable at the commit.
    load     = 1'b1;
    load_val = 4'hA;
    push_exp(1'b0, 4'hA);
    drain();

    // Slow release on digit 2: phase waits in NULL until it drops.
    load        = 1'b0;
    force_hi[2] = 1'b1;
    push_exp(1'b0, 4'hB);
    pops_before = n_pop;
    repeat (10) @(negedge clk);
    check("hold_rails_null", {sum, carryout}, 32'h0);
    check("hold_no_wave", n_pop, pops_before);
    force_hi[2] = 1'b0;
    drain();

    // Reset with two links still DATA in the NULL phase.
    @(posedge clk);
    #1 force_lo[1:0] = 2'b11;
    @(posedge clk);
    #1 check("partial_links", {sum, carryout}, {8'h0A, 2'b00});
    init_n = 1'b0;
    #1 check("async_reset_rails", {sum, carryout}, 32'h0);
    force_lo = '0;
    up       = 1'b0;
    push_exp(1'b0, 4'h0);
    push_exp(1'b1, 4'hF);
    push_exp(1'b0, 4'hE);
    @(negedge clk);
    init_n = 1'b1;
    drain();

`ifdef DR_WAVE_COUNTER_PROTOCOL_CHECK_EN
    // Completion held high on a NULL link for two DATA-phase cycles.
    push_exp(1'b0, 4'hD);
    repeat (3) @(posedge clk);
    #1 force_hi[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 force_hi[0] = 1'b0;
    check("proto_err_set", proto_err, 32'h1);
    repeat (3) @(negedge clk);
    check("proto_err_sticky", proto_err, 32'h1);
    drain();
    init_n = 1'b0;
    #1 check("proto_err_cleared", proto_err, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
